adsr: RTL
=========

ADSR -- requirements
Module: adsr

Interface
REQ-001 The block SHALL have exactly one parameter: SYNC_STAGES, default 2, the number of gate synchronizer flops (legal values 2..4).
REQ-002 clk  input  1  Envelope clock; this is the clk_adsr output of the clock divider; every register in the block uses its rising edge.
REQ-003 arstn  input  1  Reset; asynchronous and active-low.
REQ-004 gate  input  1  Note-on level from another clock domain; high = key held.
REQ-005 attack  input  4  Attack rate code a.
REQ-006 decay  input  4  Decay rate code d.
REQ-007 sustain  input  4  Sustain level code s.
REQ-008 release  input  4  Release rate code r.
REQ-009 env  output  8  Envelope amplitude, unsigned, registered.
REQ-010 state  output  3  Registered state: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
REQ-011 busy  output  1  High exactly when state != IDLE; this is a registered or decoded-from-register signal, with no combinational path from inputs.

Function
REQ-012 gate SHALL pass through a SYNC_STAGES-flop synchronizer to form gate_s, plus one more flop gate_d; rise = gate_s & ~gate_d.
REQ-013 Rate inputs SHALL map to a per-cycle step of code+1, range 1..16; the sustain level SHALL be sus8 = {s,s}, giving 0, 17, ..., 255.
REQ-014 All arithmetic SHALL use at least 9 bits internally; env SHALL never wrap, it saturates at 255 and clamps at 0 or sus8.
REQ-015 Per-edge priority: (1) rise; (2) gate_s low while in ATTACK, DECAY or SUSTAIN; (3) normal progression.
REQ-016 On rise, in any state including ATTACK: state <= ATTACK and env is held that cycle, so a retrigger continues from the current level with no reset to 0.
REQ-017 When gate_s is low in ATTACK, DECAY or SUSTAIN: state <= RELEASE and env is held that cycle.
REQ-018 IDLE: env is held (0 after reset); the block stays in IDLE until a rise.
REQ-019 ATTACK: if env + (a+1) >= 255, then env <= 255 and state <= DECAY; otherwise env <= env + (a+1).
REQ-020 DECAY: if env <= sus8 + (d+1) (this includes env <= sus8), then env <= sus8 and state <= SUSTAIN; otherwise env <= env - (d+1).
REQ-021 SUSTAIN: env <= sus8 every cycle, so sustain changes take effect one cycle later; the block stays in SUSTAIN while gate_s is high.
REQ-022 RELEASE: if env <= r+1, then env <= 0 and state <= IDLE; otherwise env <= env - (r+1); a high gate_s without a rise does not leave RELEASE.
REQ-023 Rate and sustain inputs are sampled every cycle; a change mid-phase SHALL affect the very next step.
REQ-024 Latency: a gate rising edge sampled at edge k SHALL produce state=ATTACK after edge k+SYNC_STAGES; the first env increment occurs on the following edge.
REQ-025 Unused state encodings 5..7 SHALL go to IDLE with env <= 0 on the next edge.

Reset
REQ-026 While arstn=0: env=0, state=IDLE, busy=0, and all synchronizer flops and gate_d are 0, independent of clk.
REQ-027 Reset release SHALL NOT generate a rise unless gate is later sampled high; a gate held high through reset SHALL produce a rise SYNC_STAGES+1 edges after release.
REQ-028 Reset asserted mid-operation SHALL immediately force the reset values of REQ-026, with no partial release phase.

Verification
REQ-029 Scenario 1 (full cycle): a=15, d=15, s=8 (sus8=136), r=0; gate held high -> ATTACK env 16, 32, ..., 240, 255 (16 steps); DECAY 239, 223, ..., 143, 136; SUSTAIN at 136; then gate low -> RELEASE decrements by 1 for 136 cycles to 0, then IDLE with busy=0.
REQ-030 Scenario 2 (early release): a=3, gate dropped when env=64 in ATTACK -> RELEASE entered with env held at 64 for that edge, then decreasing by r+1.
REQ-031 Scenario 3 (retrigger): gate rises while in RELEASE at env=100 -> ATTACK with env continuing from 100 (no return to 0).
REQ-032 Scenario 4 (sustain boundaries): s=15 -> DECAY completes in 1 cycle at 255; s=0 -> SUSTAIN at 0 and busy stays 1 while the gate is held; changing s in SUSTAIN moves env on the next edge.
REQ-033 Scenario 5 (reset mid-operation): arstn pulsed low mid-ATTACK between clock edges -> env=0 and state=IDLE immediately; gate held high through reset -> ATTACK after SYNC_STAGES+1 edges.
REQ-034 Scenario 6 (short gate): a 1-cycle gate pulse -> a single rise, ATTACK for exactly one edge, then RELEASE, then IDLE at env 0.

Source files
------------

// File: rtl/adsr.sv
// ADSR envelope generator: synchronises a note gate and steps an 8-bit
// envelope through attack, decay, sustain and release, saturating at 255/sus/0.
// The release-rate port is named rel because "release" is a reserved word.
module adsr #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       arstn,
    input  logic       gate,
    input  logic [3:0] attack,
    input  logic [3:0] decay,
    input  logic [3:0] sustain,
    input  logic [3:0] rel,
    output logic [7:0] env,
    output logic [2:0] state,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t                 state_q, state_n;
    logic [7:0]             env_q, env_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   gate_s, gate_d, rise;

    logic [4:0] step_a, step_d, step_r;
    logic [7:0] sus8;
    logic [8:0] sus9, env9, sum_a;

    assign gate_s = sync_q[SYNC_STAGES-1];
    assign rise   = gate_s & ~gate_d;

    assign step_a = {1'b0, attack}  + 5'd1;
    assign step_d = {1'b0, decay}   + 5'd1;
    assign step_r = {1'b0, rel}     + 5'd1;
    assign sus8   = {sustain, sustain};
    assign sus9   = {1'b0, sus8};
    assign env9   = {1'b0, env_q};
    assign sum_a  = env9 + {4'b0, step_a};

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            sync_q  <= '0;
            gate_d  <= 1'b0;
            state_q <= IDLE;
            env_q   <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], gate};
            gate_d  <= gate_s;
            state_q <= state_n;
            env_q   <= env_n;
        end
    end

    always_comb begin
        state_n = state_q;
        env_n   = env_q;
        if (!(state_q inside {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE})) begin
            state_n = IDLE;
            env_n   = '0;
        end else if (rise) begin
            // retrigger keeps the current level so the note resumes smoothly
            state_n = ATTACK;
        end else if (!gate_s && (state_q inside {ATTACK, DECAY, SUSTAIN})) begin
            state_n = RELEASE;
        end else begin
            case (state_q)
                ATTACK: begin
                    if (sum_a >= 9'd255) begin
                        env_n   = 8'd255;
                        state_n = DECAY;
                    end else begin
                        env_n = sum_a[7:0];
                    end
                end
                DECAY: begin
                    if (env9 <= sus9 + {4'b0, step_d}) begin
                        env_n   = sus8;
                        state_n = SUSTAIN;
                    end else begin
                        env_n = env_q - {3'b0, step_d};
                    end
                end
                SUSTAIN: env_n = sus8;
                RELEASE: begin
                    if (env_q <= {3'b0, step_r}) begin
                        env_n   = '0;
                        state_n = IDLE;
                    end else begin
                        env_n = env_q - {3'b0, step_r};
                    end
                end
                default: ;
            endcase
        end
    end

    assign env   = env_q;
    assign state = state_q;
    assign busy  = (state_q != IDLE);

endmodule
